// File: rtl/obs_l4_mul_sequencer_pkg.sv
// obs_pkg: shared widths, FSM state type and operand-split helpers for the
// L4 OBS multiply sequencer.
//   N       operand width (66)
//   H       half width, one sub-multiplier operand (33)
//   PW      sub-product width 2H-1 (65)
//   CW      full product width 2N-1 (131)
package obs_pkg;

  localparam int N           = 66;
  localparam int H           = N / 2;
  localparam int PW          = 2 * H - 1;
  localparam int CW          = 2 * N - 1;
  localparam int TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2,
    OUT  = 2'd3
  } state_t;

  typedef logic [1:0] idx_t;

  // Even coefficients: result bit k = v[2k]
  function automatic logic [H-1:0] even_half(input logic [N-1:0] v);
    logic [H-1:0] r;
    for (int k = 0; k < H; k++) r[k] = v[2*k];
    return r;
  endfunction

  // Odd coefficients: result bit k = v[2k+1]
  function automatic logic [H-1:0] odd_half(input logic [N-1:0] v);
    logic [H-1:0] r;
    for (int k = 0; k < H; k++) r[k] = v[2*k+1];
    return r;
  endfunction

endpackage

// File: rtl/obs_l4_mul_sequencer_if.sv
// obs_l4_mul_sequencer_if: bundles the operand input, result output and
// sub-multiplier request/ack channels plus the sticky error flags.
//   master : environment side (operand source, result sink, sub-multiplier)
//   slave  : sequencer side
interface obs_l4_mul_sequencer_if;
  import obs_pkg::*;

  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  a_in;
  logic [N-1:0]  b_in;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] c_out;
  logic          sm_req;
  logic [H-1:0]  sm_a;
  logic [H-1:0]  sm_b;
  logic          sm_ack;
  logic [PW-1:0] sm_prod;
  logic          err_timeout;
  logic          err_spurious;

  modport master (
    output in_valid, a_in, b_in, out_ready, sm_ack, sm_prod,
    input  in_ready, out_valid, c_out, sm_req, sm_a, sm_b,
           err_timeout, err_spurious
  );

  modport slave (
    input  in_valid, a_in, b_in, out_ready, sm_ack, sm_prod,
    output in_ready, out_valid, c_out, sm_req, sm_a, sm_b,
           err_timeout, err_spurious
  );

endinterface

// File: rtl/obs_l4_mul_sequencer_overlap.sv
// overlap_module_66bit: merges the four 65-bit even/odd sub-products into the
// 131-bit GF(2) product. Purely combinational.
//   p1 = Ae*Be, p2 = Ae*Bo, p3 = Ao*Be, p4 = Ao*Bo   (inputs, PW bits)
//   c  = p1(x^2) + x*(p2+p3)(x^2) + x^2*p4(x^2)      (output, CW bits)
module overlap_module_66bit
  import obs_pkg::*;
(
  input  logic [PW-1:0] p1,
  input  logic [PW-1:0] p2,
  input  logic [PW-1:0] p3,
  input  logic [PW-1:0] p4,
  output logic [CW-1:0] c
);

  for (genvar gi = 0; gi < PW; gi++) begin : g_bits
    // Odd bits come only from the cross terms
    assign c[2*gi+1] = p2[gi] ^ p3[gi];
    // Even bits: p4 is shifted up by one even position
    if (gi == 0) begin : g_lsb
      assign c[0] = p1[0];
    end else begin : g_even
      assign c[2*gi] = p1[gi] ^ p4[gi-1];
    end
  end

  assign c[CW-1] = p4[PW-1];

endmodule

// File: rtl/obs_l4_mul_sequencer.sv
// obs_l4_mul_sequencer: runs one shared 33x33 carry-less sub-multiplier four
// times (Ae*Be, Ae*Bo, Ao*Be, Ao*Bo) and merges the sub-products into a
// 131-bit GF(2) product.
//   clk  in  rising-edge clock
//   rst  in  asynchronous active-high reset
//   bus  slave modport: in_valid/in_ready/a_in/b_in operand channel,
//        out_valid/out_ready/c_out result channel, sm_req/sm_a/sm_b/sm_ack/
//        sm_prod sub-multiplier handshake, err_timeout/err_spurious flags.
module obs_l4_mul_sequencer
  import obs_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  obs_l4_mul_sequencer_if.slave   bus
);

  localparam int CNTW = $clog2(TIMEOUT + 1);

  state_t                 state_reg, state_next;
  idx_t                   idx_reg;
  logic [N-1:0]           a_reg, b_reg;
  logic [3:0][PW-1:0]     p_reg;
  logic [CNTW-1:0]        cnt_reg;
  logic                   out_valid_reg;
  logic [CW-1:0]          c_out_reg;
  logic                   err_timeout_reg, err_spurious_reg;
  logic [CW-1:0]          combined;

  logic accept, ack_ok, timed_out, out_fire;

  assign accept    = (state_reg == IDLE) && bus.in_valid;
  assign ack_ok    = (state_reg == REQ) && bus.sm_ack;
  assign timed_out = (state_reg == REQ) && !bus.sm_ack &&
                     (cnt_reg == CNTW'(TIMEOUT - 1));
  assign out_fire  = out_valid_reg && bus.out_ready;

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE: if (accept) state_next = REQ;
      REQ: begin
        if (bus.sm_ack)  state_next = (idx_reg == 2'd3) ? OUT : GAP;
        else if (timed_out) state_next = IDLE;
      end
      GAP:  state_next = REQ;
      OUT:  if (out_fire) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand routing by idx; forced to zero outside REQ so the sub-multiplier
  // only ever sees a held, meaningful pair while sm_req is high.
  always_comb begin
    bus.sm_a = '0;
    bus.sm_b = '0;
    if (state_reg == REQ) begin
      bus.sm_a = idx_reg[1] ? odd_half(a_reg) : even_half(a_reg);
      bus.sm_b = idx_reg[0] ? odd_half(b_reg) : even_half(b_reg);
    end
  end

  assign bus.sm_req       = (state_reg == REQ);
  assign bus.in_ready     = (state_reg == IDLE);
  assign bus.out_valid    = out_valid_reg;
  assign bus.c_out        = c_out_reg;
  assign bus.err_timeout  = err_timeout_reg;
  assign bus.err_spurious = err_spurious_reg;

  overlap_module_66bit u_overlap (
    .p1 (p_reg[0]),
    .p2 (p_reg[1]),
    .p3 (p_reg[2]),
    .p4 (p_reg[3]),
    .c  (combined)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= IDLE;
      idx_reg          <= '0;
      a_reg            <= '0;
      b_reg            <= '0;
      p_reg            <= '0;
      cnt_reg          <= '0;
      out_valid_reg    <= 1'b0;
      c_out_reg        <= '0;
      err_timeout_reg  <= 1'b0;
      err_spurious_reg <= 1'b0;
    end else begin
      state_reg <= state_next;

      if (accept) begin
        a_reg   <= bus.a_in;
        b_reg   <= bus.b_in;
        idx_reg <= '0;
      end

      if (ack_ok) begin
        p_reg[idx_reg] <= bus.sm_prod;
        if (idx_reg != 2'd3) idx_reg <= idx_reg + 2'd1;
      end

      // Counts consecutive REQ cycles with no ack; any other cycle restarts it
      if ((state_reg == REQ) && !bus.sm_ack && !timed_out) cnt_reg <= cnt_reg + 1'b1;
      else cnt_reg <= '0;

      // The last product lands on the REQ->OUT edge, so the merge is captured
      // on the first OUT cycle and out_valid rises together with c_out.
      if ((state_reg == OUT) && !out_valid_reg) c_out_reg <= combined;
      out_valid_reg <= (state_reg == OUT) && !out_fire;

      if (timed_out) err_timeout_reg <= 1'b1;
      if (bus.sm_ack && (state_reg != REQ)) err_spurious_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_obs_l4_mul_sequencer.sv
module tb_obs_l4_mul_sequencer;
  import obs_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  obs_l4_mul_sequencer_if bus();

  obs_l4_mul_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference sub-multiplier behaviour (responder only, not the sequencer)
  function automatic logic [64:0] clmul33(input logic [32:0] x, input logic [32:0] y);
    logic [64:0] r;
    r = '0;
    for (int i = 0; i < 33; i++) if (y[i]) r = r ^ (65'(x) << i);
    return r;
  endfunction

  task automatic drive_idle();
    bus.in_valid  = 1'b0;
    bus.a_in      = '0;
    bus.b_in      = '0;
    bus.out_ready = 1'b0;
    bus.sm_ack    = 1'b0;
    bus.sm_prod   = '0;
  endtask

  // Launches one operation and answers sub-multiply requests after 'delay'
  // unacknowledged REQ cycles. Returns edges from accept to out_valid, the
  // number of REQ gaps not exactly one cycle long, and sm_a/sm_b changes under req.
  task automatic run_op(input logic [65:0] a, input logic [65:0] b, input int delay,
                        output int lat, output int bad_gaps, output int unstable);
    int req_run, gap_len;
    bit seen, prev_req;
    logic [32:0] sa, sb;
    lat = -1; bad_gaps = 0; unstable = 0;
    req_run = 0; gap_len = 0; seen = 0; prev_req = 0; sa = '0; sb = '0;
    bus.a_in = a; bus.b_in = b; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (bus.out_valid) begin
        lat = cyc;
        break;
      end
      if (bus.sm_req) begin
        if (!prev_req) begin
          if (seen && gap_len != 1) bad_gaps++;
          seen = 1; req_run = 0; sa = bus.sm_a; sb = bus.sm_b;
        end else if (bus.sm_a !== sa || bus.sm_b !== sb) begin
          unstable++;
        end
        req_run++;
        if (req_run > delay) begin
          bus.sm_ack  = 1'b1;
          bus.sm_prod = clmul33(bus.sm_a, bus.sm_b);
        end
        gap_len = 0;
      end else begin
        gap_len++;
      end
      prev_req = bus.sm_req;
      @(posedge clk); #1;
      bus.sm_ack = 1'b0; bus.sm_prod = '0;
    end
    $display("op a=%0h b=%0h delay=%0d c_out=%0h latency=%0d", a, b, delay, bus.c_out, lat);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    n_checks++; if (bus.sm_req !== 1'b0) begin n_fail++; $display("FAIL reset_sm_req got %b want 0", bus.sm_req); end
    n_checks++; if (bus.sm_a !== 33'd0 || bus.sm_b !== 33'd0) begin n_fail++; $display("FAIL reset_sm_ops got %0h/%0h want 0/0", bus.sm_a, bus.sm_b); end
    n_checks++; if (bus.c_out !== 131'd0) begin n_fail++; $display("FAIL reset_c_out got %0h want 0", bus.c_out); end
    n_checks++; if (bus.err_timeout !== 1'b0 || bus.err_spurious !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b%b want 00", bus.err_timeout, bus.err_spurious); end
    rst = 1'b0;
    $display("reset released");
  endtask

  task automatic finish_handshake(input string name);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_release got out_valid=%b in_ready=%b want 0/1", name, bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_basic();
    int lat, bg, us;
    run_op(66'd1, 66'd1, 0, lat, bg, us);
    n_checks++; if (lat !== 8) begin n_fail++; $display("FAIL basic_latency got %0d want 8", lat); end
    n_checks++; if (bus.c_out !== 131'd1) begin n_fail++; $display("FAIL basic_c_out got %0h want 1", bus.c_out); end
    n_checks++; if (bg !== 0) begin n_fail++; $display("FAIL basic_gap got %0d bad gaps want 0", bg); end
    finish_handshake("basic");
  endtask

  task automatic test_top_bits();
    int lat, bg, us;
    logic [65:0]  a;
    logic [130:0] exp;
    a   = 66'd1 << 65;
    exp = 131'd1 << 130;
    run_op(a, a, 0, lat, bg, us);
    n_checks++; if (bus.c_out !== exp) begin n_fail++; $display("FAIL top_bits_c_out got %0h want %0h", bus.c_out, exp); end
    finish_handshake("top_bits");
  endtask

  task automatic test_odd_even();
    logic [65:0]  va [3] = '{66'd3, 66'd3, 66'd5};
    logic [65:0]  vb [3] = '{66'd3, 66'd1, 66'd6};
    logic [130:0] vc [3] = '{131'd5, 131'd3, 131'd30};
    int lat, bg, us;
    for (int i = 0; i < 3; i++) begin
      run_op(va[i], vb[i], 0, lat, bg, us);
      n_checks++;
      if (bus.c_out !== vc[i]) begin
        n_fail++;
        $display("FAIL odd_even_%0d_c_out got %0h want %0h", i, bus.c_out, vc[i]);
      end
      finish_handshake("odd_even");
    end
  endtask

  task automatic test_ack_delay();
    int lat, bg, us;
    run_op(66'd5, 66'd6, 4, lat, bg, us);
    n_checks++; if (lat !== 24) begin n_fail++; $display("FAIL delay_latency got %0d want 24", lat); end
    n_checks++; if (us !== 0) begin n_fail++; $display("FAIL delay_stable got %0d changes want 0", us); end
    n_checks++; if (bg !== 0) begin n_fail++; $display("FAIL delay_gap got %0d bad gaps want 0", bg); end
    n_checks++; if (bus.c_out !== 131'd30) begin n_fail++; $display("FAIL delay_c_out got %0h want 1e", bus.c_out); end
    finish_handshake("delay");
  endtask

  task automatic test_backpressure();
    int lat, bg, us, bad;
    run_op(66'd3, 66'd1, 0, lat, bg, us);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b1 || bus.c_out !== 131'd3 || bus.in_ready !== 1'b0) bad++;
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL hold_out got %0d bad cycles want 0", bad); end
    // New operands already offered during the handshake must not be taken
    bus.a_in = 66'd1; bus.b_in = 66'd1; bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0; bus.in_valid = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_release got out_valid=%b in_ready=%b want 0/1", bus.out_valid, bus.in_ready);
    end
    $display("backpressure hold done, in_ready=%b", bus.in_ready);
  endtask

  task automatic test_timeout();
    int seen_valid;
    bus.a_in = 66'd1; bus.b_in = 66'd1; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (254) @(posedge clk);
    #1;
    n_checks++;
    if (bus.sm_req !== 1'b1 || bus.err_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_early got sm_req=%b err_timeout=%b want 1/0", bus.sm_req, bus.err_timeout);
    end
    @(posedge clk); #1;
    n_checks++;
    if (bus.err_timeout !== 1'b1 || bus.in_ready !== 1'b1 || bus.sm_req !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_abort got err=%b in_ready=%b sm_req=%b want 1/1/0", bus.err_timeout, bus.in_ready, bus.sm_req);
    end
    seen_valid = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen_valid++;
    end
    n_checks++; if (seen_valid !== 0) begin n_fail++; $display("FAIL timeout_no_out got %0d valid cycles want 0", seen_valid); end
    $display("timeout op dropped, err_timeout=%b", bus.err_timeout);
  endtask

  task automatic test_spurious();
    n_checks++; if (bus.err_spurious !== 1'b0) begin n_fail++; $display("FAIL spurious_pre got %b want 0", bus.err_spurious); end
    bus.sm_ack = 1'b1; bus.sm_prod = 65'h1_2345;
    @(posedge clk); #1;
    bus.sm_ack = 1'b0; bus.sm_prod = '0;
    n_checks++; if (bus.err_spurious !== 1'b1) begin n_fail++; $display("FAIL spurious_flag got %b want 1", bus.err_spurious); end
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.err_timeout !== 1'b1) begin
      n_fail++;
      $display("FAIL spurious_state got in_ready=%b out_valid=%b err_timeout=%b want 1/0/1", bus.in_ready, bus.out_valid, bus.err_timeout);
    end
    $display("spurious ack in idle, err_spurious=%b", bus.err_spurious);
  endtask

  task automatic test_rst_mid();
    int lat, bg, us;
    bus.a_in = 66'd3; bus.b_in = 66'd3; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    n_checks++; if (bus.sm_req !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pre got sm_req=%b want 1", bus.sm_req); end
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.sm_req !== 1'b0 || bus.sm_a !== 33'd0 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_async got sm_req=%b sm_a=%0h in_ready=%b out_valid=%b want 0/0/1/0", bus.sm_req, bus.sm_a, bus.in_ready, bus.out_valid);
    end
    n_checks++;
    if (bus.c_out !== 131'd0 || bus.err_timeout !== 1'b0 || bus.err_spurious !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_regs got c_out=%0h err=%b%b want 0/00", bus.c_out, bus.err_timeout, bus.err_spurious);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    run_op(66'd3, 66'd3, 1, lat, bg, us);
    n_checks++; if (bus.c_out !== 131'd5 || lat !== 12) begin n_fail++; $display("FAIL rst_mid_recover got c_out=%0h lat=%0d want 5/12", bus.c_out, lat); end
    finish_handshake("rst_mid");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    @(posedge clk); #1;
    test_basic();
    test_top_bits();
    test_odd_even();
    test_ack_delay();
    test_backpressure();
    test_timeout();
    test_spurious();
    test_rst_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
